// File: rtl/zhxpu_pkg.sv
// -----------------------------------------------------------------------------
// zhxpu_pkg
// Shared widths and the memory-access state encoding for the zhxpu pipeline.
//   ADDR_W      : SRAM word address width
//   DATA_W      : SRAM / register data width
//   REG_W       : register-file index width
//   mem_state_t : memory-access stage states
// -----------------------------------------------------------------------------
package zhxpu_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [2:0] {
        MEM_IDLE     = 3'd0,
        MEM_RD_ACT   = 3'd1,
        MEM_WR_SETUP = 3'd2,
        MEM_WR_PULSE = 3'd3,
        MEM_WR_HOLD  = 3'd4
    } mem_state_t;

    // States in which a new request from the execute stage is taken.
    function automatic logic mem_is_accepting(input mem_state_t s);
        return (s == MEM_IDLE) || (s == MEM_WR_HOLD);
    endfunction

    // States in which the store data is on the SRAM bus.
    function automatic logic mem_drives_bus(input mem_state_t s);
        return (s == MEM_WR_SETUP) || (s == MEM_WR_PULSE) || (s == MEM_WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_bus_drv.sv
// -----------------------------------------------------------------------------
// sram_bus_drv
// Registered strobes and tri-state data driver for an asynchronous 16-bit
// memory bus. Strobe requests are active-high and describe the coming cycle;
// they are registered here so the pins change cleanly on the clock edge.
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   i_ce       in   assert chip enable next cycle
//   i_oe       in   assert output enable next cycle
//   i_we       in   assert write enable next cycle
//   i_drive    in   drive i_wr_data onto the bus next cycle
//   i_wr_data  in   data to drive while driving
//   o_rd_data  out  current bus value
//   ram_ce_n   out  chip enable, active-low
//   ram_oe_n   out  output enable, active-low
//   ram_we_n   out  write enable, active-low
//   ram_data   io   bidirectional data bus
// -----------------------------------------------------------------------------
module sram_bus_drv
    import zhxpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    input  logic              i_oe,
    input  logic              i_we,
    input  logic              i_drive,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    inout  wire  [DATA_W-1:0] ram_data
);

    logic r_drive;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            r_drive  <= 1'b0;
        end else begin
            ram_ce_n <= ~i_ce;
            ram_oe_n <= ~i_oe;
            ram_we_n <= ~i_we;
            r_drive  <= i_drive;
        end
    end

    assign ram_data  = r_drive ? i_wr_data : {DATA_W{1'bz}};
    assign o_rd_data = ram_data;

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access stage: runs loads and stores on an external asynchronous SRAM,
// registers the writeback bundle and stalls upstream while the SRAM is busy.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   MEM_IDLE     | bus released; takes the current execute-stage request
//   MEM_RD_ACT   | ce/oe low, bus released; samples data when cnt reaches 0
//   MEM_WR_SETUP | ce low, data driven ahead of the write strobe
//   MEM_WR_PULSE | ce/we low, data driven; leaves when cnt reaches 0
//   MEM_WR_HOLD  | we released, data held; takes the next request like IDLE
//
// Parameters:
//   RD_CYCLES  output-enable low time before sampling (1..15)
//   WR_CYCLES  write-enable low time (1..15)
// Ports:
//   clk, rst (sync, active-low)
//   exe_memrd_ctrl / exe_memwr_ctrl / exe_mem_addr / exe_wr_data  request
//   exe_alu_res / exe_wb_reg / exe_wb_en                          writeback in
//   stall                       hold upstream stages this cycle
//   wb_data / wb_reg / wb_en    registered writeback bundle
//   err                         sticky: load and store requested together
//   ram_addr / ram_data / ram_ce_n / ram_oe_n / ram_we_n   SRAM bus
// -----------------------------------------------------------------------------
module mem_access
    import zhxpu_pkg::*;
#(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_memrd_ctrl,
    input  logic              exe_memwr_ctrl,
    input  logic [ADDR_W-1:0] exe_mem_addr,
    input  logic [DATA_W-1:0] exe_wr_data,
    input  logic [DATA_W-1:0] exe_alu_res,
    input  logic [REG_W-1:0]  exe_wb_reg,
    input  logic              exe_wb_en,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic              wb_en,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    // Counters run from N-1 down to 0, so the phase lasts exactly N cycles.
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_rd_wb_en;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_accept;
    logic              w_cnt_zero;

    assign w_accept   = mem_is_accepting(r_state);
    assign w_cnt_zero = (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MEM_IDLE, MEM_WR_HOLD: begin
                if (exe_memwr_ctrl)      w_state_nxt = MEM_WR_SETUP;
                else if (exe_memrd_ctrl) w_state_nxt = MEM_RD_ACT;
                else                     w_state_nxt = MEM_IDLE;
            end
            MEM_RD_ACT:   if (w_cnt_zero) w_state_nxt = MEM_IDLE;
            MEM_WR_SETUP: w_state_nxt = MEM_WR_PULSE;
            MEM_WR_PULSE: if (w_cnt_zero) w_state_nxt = MEM_WR_HOLD;
            default:      w_state_nxt = MEM_IDLE;
        endcase
    end

    // Upstream is released in the last read cycle and in WR_HOLD, so the next
    // instruction is presented exactly when this stage can take it.
    assign stall = (w_accept && (exe_memrd_ctrl || exe_memwr_ctrl))
                || ((r_state == MEM_RD_ACT) && !w_cnt_zero)
                || (r_state == MEM_WR_SETUP)
                || (r_state == MEM_WR_PULSE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= MEM_IDLE;
            r_cnt      <= 4'd0;
            r_rd_wb_en <= 1'b0;
            r_wr_data  <= '0;
            wb_data    <= '0;
            wb_reg     <= '0;
            wb_en      <= 1'b0;
            err        <= 1'b0;
            ram_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MEM_IDLE, MEM_WR_HOLD: begin
                    if (exe_memwr_ctrl) begin
                        // A store wins over a simultaneous load; flag the clash.
                        ram_addr  <= exe_mem_addr;
                        r_wr_data <= exe_wr_data;
                        wb_en     <= 1'b0;
                        if (exe_memrd_ctrl) err <= 1'b1;
                    end else if (exe_memrd_ctrl) begin
                        ram_addr   <= exe_mem_addr;
                        wb_reg     <= exe_wb_reg;
                        r_rd_wb_en <= exe_wb_en;
                        r_cnt      <= RD_LOAD;
                        wb_en      <= 1'b0;
                    end else begin
                        wb_data <= exe_alu_res;
                        wb_reg  <= exe_wb_reg;
                        wb_en   <= exe_wb_en;
                    end
                end
                MEM_RD_ACT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                        wb_en <= 1'b0;
                    end else begin
                        wb_data <= w_rd_data;
                        wb_en   <= r_rd_wb_en;
                    end
                end
                MEM_WR_SETUP: begin
                    r_cnt <= WR_LOAD;
                    wb_en <= 1'b0;
                end
                MEM_WR_PULSE: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 4'd1;
                    wb_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes are derived from the next state so the registered pins line up
    // with the state they belong to. A load straight after WR_HOLD releases the
    // bus on the same edge that lowers oe_n, so they never overlap.
    sram_bus_drv u_bus_drv (
        .clk       (clk),
        .rst       (rst),
        .i_ce      (w_state_nxt != MEM_IDLE),
        .i_oe      (w_state_nxt == MEM_RD_ACT),
        .i_we      (w_state_nxt == MEM_WR_PULSE),
        .i_drive   (mem_drives_bus(w_state_nxt)),
        .i_wr_data (r_wr_data),
        .o_rd_data (w_rd_data),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_data  (ram_data)
    );

endmodule
